// File: rtl/rf_ctrl_pkg.sv
// Shared constants and grant-source encoding for the register-file write path.
package rf_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_LU   = 2'd2
    } gnt_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small FIFO buffering long-latency results until the write port is free.
// Pointers wrap modulo DEPTH; occupancy is kept in a separate counter.
module rf_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between WB (priority) and the
// buffered long-latency results, and tracks pending long-latency destinations.
module rf_write_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_W   = rf_ctrl_pkg::DATA_W,
    parameter int ADDR_W   = rf_ctrl_pkg::ADDR_W,
    parameter int LU_DEPTH = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    input  logic [ADDR_W-1:0] rd_id,
    output logic              busy_a,
    output logic              busy_b,
    output logic              busy_d,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int NREG = 2 ** ADDR_W;
    localparam int WW   = $clog2(MAX_WAIT + 1);

    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic                     full, empty, push, pop;
    gnt_src_e                 gnt;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [NREG-1:0]   pending_q, pending_d;

    assign push = lu_valid && lu_ready;
    assign {head_addr, head_data} = head;

    rf_wb_fifo #(
        .DEPTH (LU_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({lu_addr, lu_data}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // A head addressed to r0 is popped whenever WB is idle but never granted.
    always_comb begin
        gnt = GNT_NONE;
        pop = 1'b0;
        if (wb_we && (wb_addr != '0)) begin
            gnt = GNT_WB;
        end else if (!empty) begin
            pop = 1'b1;
            if (head_addr != '0) begin
                gnt = GNT_LU;
            end
        end
    end

    always_comb begin
        rf_we_d    = (gnt != GNT_NONE);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (gnt)
            GNT_WB: begin
                rf_waddr_d = wb_addr;
                rf_wdata_d = wb_data;
            end
            GNT_LU: begin
                rf_waddr_d = head_addr;
                rf_wdata_d = head_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        wait_cnt_d = '0;
        if (!empty && !pop) begin
            wait_cnt_d = (wait_cnt_q == WW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    // Issue of a register beats a same-edge commit of that register.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_reg
                assign pending_d[gi] = (iss_valid && (iss_addr == ADDR_W'(gi))) ? 1'b1 :
                                       ((gnt == GNT_LU) && (head_addr == ADDR_W'(gi))) ? 1'b0 :
                                       pending_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wait_cnt_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wait_cnt_q <= wait_cnt_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign lu_ready = !full;
    assign wb_stall = (wait_cnt_q == WW'(MAX_WAIT));
    assign busy_a   = pending_q[rs_a];
    assign busy_b   = pending_q[rs_b];
    assign busy_d   = pending_q[rd_id];

endmodule
